dmem_access_ctrl: RTL

//   Sequences MEM-stage loads/stores onto a variable-latency data memory (req/ack handshake).

---
 rtl/dmem_access_ctrl.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl
// Puts MEM-stage loads and stores onto a data memory whose latency varies,
// using a req/ack handshake. While an access is outstanding, stall_o holds
// PC, IF_ID, ID_EX and EX_MEM. A timeout bounds each access, and err_o is a
// sticky flag for timeouts and for read+write conflicts.
module dmem_access_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              mem_read_i,
    input  logic              mem_write_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              stall_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              err_o,
    output logic              req_o,
    output logic              we_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [DATA_W-1:0] wdata_o,
    input  logic              ack_i,
    input  logic [DATA_W-1:0] rdata_i
);

    // The counter is wide enough to hold TIMEOUT. It stops at TIMEOUT-1,
    // so it can never wrap.
    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic [CNT_W-1:0]    cnt_r;
    logic [CNT_W-1:0]    cnt_s;
    logic                req_r;
    logic                req_s;
    logic                we_r;
    logic                we_s;
    logic [ADDR_W-1:0]   addr_r;
    logic [ADDR_W-1:0]   addr_s;
    logic [DATA_W-1:0]   wdata_r;
    logic [DATA_W-1:0]   wdata_s;
    logic [DATA_W-1:0]   rdata_r;
    logic [DATA_W-1:0]   rdata_s;
    logic                err_r;
    logic                err_s;
    logic                stall_s;
    logic                access_s;
    logic                conflict_s;

    assign access_s   = mem_read_i | mem_write_i;
    assign conflict_s = mem_read_i & mem_write_i;

    // Next-state and next-register logic. Every value defaults to hold.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        req_s   = req_r;
        we_s    = we_r;
        addr_s  = addr_r;
        wdata_s = wdata_r;
        rdata_s = rdata_r;
        err_s   = err_r;
        stall_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (access_s) begin
                    // Stall in this same cycle. Launch the request at the next edge.
                    // When read and write are both high, the store is the one performed.
                    stall_s = 1'b1;
                    addr_s  = addr_i;
                    wdata_s = wdata_i;
                    we_s    = mem_write_i;
                    req_s   = 1'b1;
                    cnt_s   = CNT_ZERO;
                    err_s   = err_r | conflict_s;
                    state_s = ST_BUSY;
                end else begin
                    stall_s = 1'b0;
                    state_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                stall_s = 1'b1;
                if (ack_i) begin
                    // If ack and timeout arrive in the same cycle, ack wins.
                    rdata_s = we_r ? {DATA_W{1'b0}} : rdata_i;
                    req_s   = 1'b0;
                    state_s = ST_DONE;
                end else if (cnt_r == CNT_LAST) begin
                    rdata_s = {DATA_W{1'b0}};
                    err_s   = 1'b1;
                    req_s   = 1'b0;
                    state_s = ST_DONE;
                end else begin
                    cnt_s   = cnt_r + CNT_ONE;
                end
            end
            ST_DONE: begin
                // The pipeline advances here. The access still on the inputs has
                // already been served, so it is not restarted.
                stall_s = 1'b0;
                state_s = ST_IDLE;
            end
            default: begin
                stall_s = 1'b0;
                req_s   = 1'b0;
                state_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Memory-side and MEM_WB-side registers plus the timeout counter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_r   <= CNT_ZERO;
            req_r   <= 1'b0;
            we_r    <= 1'b0;
            addr_r  <= {ADDR_W{1'b0}};
            wdata_r <= {DATA_W{1'b0}};
            rdata_r <= {DATA_W{1'b0}};
            err_r   <= 1'b0;
        end else begin
            cnt_r   <= cnt_s;
            req_r   <= req_s;
            we_r    <= we_s;
            addr_r  <= addr_s;
            wdata_r <= wdata_s;
            rdata_r <= rdata_s;
            err_r   <= err_s;
        end
    end

    // The pipeline must see stall_o in the same cycle as the access, so stall_o
    // is combinational. It is forced low while reset is asserted.
    assign stall_o = stall_s & ~rst_i;
    assign req_o   = req_r;
    assign we_o    = we_r;
    assign addr_o  = addr_r;
    assign wdata_o = wdata_r;
    assign rdata_o = rdata_r;
    assign err_o   = err_r;

endmodule
